// File: rtl/echo_fifo_if.sv
// Bus bundle for echo_fifo: receiver strobe in, transmitter request out, fill and overflow status.
// Handshake: rx side is a one-cycle strobe with no backpressure; tx byte is taken when o_tx_stb && !i_tx_busy.
interface echo_fifo_if #(
    parameter int LGFLEN = 4
);
    logic              i_rx_stb;
    logic [7:0]        i_rx_data;
    logic              i_tx_busy;
    logic              o_tx_stb;
    logic [7:0]        o_tx_data;
    logic [LGFLEN:0]   o_fill;
    logic              i_clr_overflow;
    logic              o_overflow;
    logic              lf_pending;

    modport master (
        output i_rx_stb, i_rx_data, i_tx_busy, i_clr_overflow,
        input  o_tx_stb, o_tx_data, o_fill, o_overflow, lf_pending
    );

    modport slave (
        input  i_rx_stb, i_rx_data, i_tx_busy, i_clr_overflow,
        output o_tx_stb, o_tx_data, o_fill, o_overflow, lf_pending
    );
endinterface

// File: rtl/echo_fifo.sv
// Byte FIFO between a UART receiver and transmitter with sticky overflow flag.
// Optional macro ECHO_FIFO_CRLF_EN: a received CR is followed by an inserted LF.
module echo_fifo #(
    parameter int LGFLEN = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    echo_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << LGFLEN;
    localparam logic [LGFLEN:0] FULL_CNT = (LGFLEN + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [LGFLEN-1:0] rd_ptr;
    logic [LGFLEN-1:0] wr_ptr;
    logic [LGFLEN:0]   fill;
    logic              overflow;

    logic              full;
    logic              pop;
    logic              push_req;
    logic              push;
    logic              collide;
    logic              drop;
    logic [7:0]        push_data;

    assign full = (fill == FULL_CNT);
    assign pop  = (fill != '0) && !bus.i_tx_busy;

`ifdef ECHO_FIFO_CRLF_EN
    typedef enum logic {ST_IDLE, ST_LF} state_t;
    state_t state;
    state_t state_nx;

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_nx;
    end

    // LF is owed only when the CR itself made it into the buffer.
    always_comb begin
        state_nx = ST_IDLE;
        if (state == ST_IDLE && bus.i_rx_stb && bus.i_rx_data == 8'h0D && (!full || pop))
            state_nx = ST_LF;
    end

    always_comb begin
        push_req  = bus.i_rx_stb;
        push_data = bus.i_rx_data;
        collide   = 1'b0;
        if (state == ST_LF) begin
            push_req  = 1'b1;
            push_data = 8'h0A;
            collide   = bus.i_rx_stb;
        end
    end

    assign bus.lf_pending = (state == ST_LF);
`else
    assign push_req       = bus.i_rx_stb;
    assign push_data      = bus.i_rx_data;
    assign collide        = 1'b0;
    assign bus.lf_pending = 1'b0;
`endif

    // A full buffer still accepts when the head leaves in the same cycle.
    assign push = push_req && (!full || pop);
    assign drop = (push_req && full && !pop) || collide;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            if (drop)                    overflow <= 1'b1;
            else if (bus.i_clr_overflow) overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !i_reset) mem[wr_ptr] <= push_data;
    end

    assign bus.o_tx_stb   = (fill != '0);
    assign bus.o_tx_data  = mem[rd_ptr];
    assign bus.o_fill     = fill;
    assign bus.o_overflow = overflow;
endmodule

// File: tb/tb_echo_fifo.sv
// Randomized scoreboard bench for echo_fifo against a queue-based reference model.
// Define ECHO_FIFO_CRLF_EN on both bench and RTL to exercise CR/LF insertion.
module tb_echo_fifo;
    localparam int LGFLEN = 4;
    localparam int DEPTH  = 1 << LGFLEN;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    echo_fifo_if #(.LGFLEN(LGFLEN)) bus ();

    echo_fifo #(.LGFLEN(LGFLEN)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    int  m_fill = 0;
    bit  m_ovf  = 1'b0;
    bit  m_pend = 1'b0;
    bit  mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides what the FIFO should do with it.
    task automatic cycle(input bit stb, input logic [7:0] d, input bit busy,
                         input bit clr, input bit r = 1'b0);
        bit pop, have, acc, drop, n_pend;
        logic [7:0] b;
        @(negedge clk);
        #2;
        rst                = r;
        bus.i_rx_stb       = stb;
        bus.i_rx_data      = d;
        bus.i_tx_busy      = busy;
        bus.i_clr_overflow = clr;
        pop    = (m_fill > 0) && !busy;
        have   = stb;
        b      = d;
        drop   = 1'b0;
        n_pend = 1'b0;
`ifdef ECHO_FIFO_CRLF_EN
        if (m_pend) begin
            have = 1'b1;
            b    = 8'h0A;
            drop = stb;
        end
`endif
        acc = have && ((m_fill < DEPTH) || pop);
        if (have && !acc) drop = 1'b1;
`ifdef ECHO_FIFO_CRLF_EN
        n_pend = !m_pend && stb && (d == 8'h0D) && acc;
`endif
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            m_fill = 0;
            m_ovf  = 1'b0;
            m_pend = 1'b0;
        end else begin
            if (acc) exp_q.push_back(b);
            m_fill = m_fill + int'(acc) - int'(pop);
            if (drop)     m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            m_pend = n_pend;
        end
    endtask

    task automatic idle(input int n, input bit busy);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, busy, 1'b0);
    endtask

    // Monitor: runs after the driver has set this cycle's inputs.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (mon_en) begin
                chk("fill", int'(bus.o_fill), m_fill);
                chk("overflow", int'(bus.o_overflow), int'(m_ovf));
                chk("tx_stb", int'(bus.o_tx_stb), int'(m_fill != 0));
                chk("lf_pending", int'(bus.lf_pending), int'(m_pend));
                if (bus.o_tx_stb === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("tx_stb_with_no_expected_byte", int'(exp_q.size() > 0), 1);
                    end else begin
                        chk("tx_data", int'(bus.o_tx_data), int'(exp_q[0]));
                        if (!bus.i_tx_busy && !rst) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bus.i_rx_stb       = 1'b0;
        bus.i_rx_data      = 8'h00;
        bus.i_tx_busy      = 1'b0;
        bus.i_clr_overflow = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;

        // single byte, one-cycle latency
        idle(6, 1'b0);
        cycle(1'b1, 8'h41, 1'b0, 1'b0);
        idle(3, 1'b0);

        // fill to depth with tx busy, overflow on extra byte, drain in order
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
        cycle(1'b1, 8'h10, 1'b1, 1'b0);
        idle(2, 1'b1);
        idle(DEPTH + 3, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // full buffer: push and pop together
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        idle(2, 1'b1);
        idle(DEPTH + 3, 1'b0);

        // overflow clear with and without a simultaneous drop
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 8'(i * 3), 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        idle(1, 1'b1);
        cycle(1'b1, 8'hEE, 1'b1, 1'b1);
        idle(1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        idle(DEPTH + 3, 1'b0);

        // reset mid-operation, rx strobe during reset ignored
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h7E, 1'b0, 1'b0);
        idle(4, 1'b0);

        // CR handling, spaced bytes
        cycle(1'b1, 8'h61, 1'b0, 1'b0);
        idle(19, 1'b0);
        cycle(1'b1, 8'h0D, 1'b0, 1'b0);
        idle(19, 1'b0);
        cycle(1'b1, 8'h62, 1'b0, 1'b0);
        idle(19, 1'b0);

        // CR immediately followed by another byte, and CR into the last free slot
        cycle(1'b1, 8'h0D, 1'b0, 1'b0);
        cycle(1'b1, 8'h44, 1'b0, 1'b0);
        idle(4, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b1, 1'b0);
        cycle(1'b1, 8'h0D, 1'b1, 1'b0);
        idle(2, 1'b1);
        idle(DEPTH + 3, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 7) == 0) ? 8'h0D : 8'($urandom_range(0, 255));
            cycle(bit'($urandom_range(0, 1)), d, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
        end

        idle(DEPTH + 4, 1'b0);
        @(negedge clk);
        #5;
        chk("drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/echo_fifo.md
ECHO_FIFO -- requirements
Module: echo_fifo

Interface
REQ-001 Parameter LGFLEN, default 4, log2 of FIFO depth (depth = 2^LGFLEN bytes, LGFLEN 2..10).
REQ-002 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 i_reset  input  1  synchronous, active-high reset.
REQ-004 i_rx_stb  input  1  one-cycle strobe from receiver: i_rx_data valid; no backpressure possible.
REQ-005 i_rx_data  input  8  received byte.
REQ-006 i_tx_busy  input  1  transmitter busy; byte accepted in cycle with o_tx_stb && !i_tx_busy.
REQ-007 o_tx_stb  output  1  byte request to transmitter (txuart i_wr).
REQ-008 o_tx_data  output  8  byte to transmit.
REQ-009 o_fill  output  LGFLEN+1  bytes currently held.
REQ-010 i_clr_overflow  input  1  clears sticky overflow flag.
REQ-011 o_overflow  output  1  sticky: at least one byte dropped.

Function
REQ-012 Circular buffer, LGFLEN-bit read/write pointers wrapping modulo 2^LGFLEN; full when o_fill == 2^LGFLEN, empty when o_fill == 0.
REQ-013 Push: i_rx_stb && (not full || pop this cycle) writes i_rx_data at write pointer, advances it.
REQ-014 Pop: o_tx_stb && !i_tx_busy advances read pointer.
REQ-015 o_tx_stb = (o_fill != 0); o_tx_data = entry at read pointer; both stable while i_tx_busy high.
REQ-016 Latency: byte pushed into empty FIFO in cycle N gives o_tx_stb=1 with that byte in cycle N+1; no combinational rx-to-tx bypass.
REQ-017 Simultaneous push and pop: o_fill unchanged; allowed when full (slot freed same cycle) and when empty is impossible (pop needs o_fill != 0).
REQ-018 Push when full without pop: byte dropped, pointers unchanged, o_overflow set next cycle.
REQ-019 i_clr_overflow clears o_overflow next cycle; a drop in the same cycle wins (o_overflow stays 1).
REQ-020 Bytes leave in arrival order; no byte duplicated or reordered.
REQ-021 o_fill updates registered: +1 push only, -1 pop only, unchanged both/neither.

Reset
REQ-022 i_reset high: pointers 0, o_fill 0, o_tx_stb 0, o_overflow 0, LF-pending 0; FIFO contents not cleared.
REQ-023 Reset mid-operation discards queued bytes; a pending handshake is abandoned; i_rx_stb during reset ignored.
REQ-024 First push honoured in cycle after i_reset deasserts.

Configuration
REQ-025 Macro ECHO_FIFO_CRLF_EN defined: received 0x0D pushes 0x0D and sets LF-pending; next cycle 0x0A pushed (same full/drop rules), LF-pending cleared.
REQ-026 With ECHO_FIFO_CRLF_EN: i_rx_stb while LF-pending -> new byte dropped, o_overflow set; LF still pushed.
REQ-027 With ECHO_FIFO_CRLF_EN: CR accepted but LF finds FIFO full -> LF dropped, o_overflow set, LF-pending cleared.
REQ-028 ECHO_FIFO_CRLF_EN undefined: no LF-pending state; 0x0D treated as any byte.

Verification
REQ-029 LGFLEN=4, i_tx_busy=0, strobe 0x41 at cycle 10 -> o_tx_stb=1, o_tx_data=0x41 at cycle 11, o_fill 1 then 0 at cycle 12.
REQ-030 i_tx_busy=1, push 0x00..0x0F -> o_fill=16; push 0x10 -> dropped, o_overflow=1; release busy -> 0x00..0x0F out in order, o_fill reaches 0.
REQ-031 Full FIFO, push 0x55 same cycle as pop -> o_fill stays 16, o_overflow stays 0, 0x55 emitted last.
REQ-032 o_overflow=1, assert i_clr_overflow with no drop -> 0 next cycle; assert with simultaneous drop -> stays 1.
REQ-033 o_fill=5, o_tx_stb=1, pulse i_reset -> next cycle o_fill=0, o_tx_stb=0, o_overflow=0; subsequent 0x7E emitted alone.
REQ-034 ECHO_FIFO_CRLF_EN defined, push 0x61,0x0D,0x62 spaced 20 cycles, busy=0 -> output 0x61,0x0D,0x0A,0x62; undefined -> 0x61,0x0D,0x62.
